// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] sizes, step-select codes and sequencer state type.
// The KECCAK_REDUCED_ROUNDS_EN build uses first_round_for() to map a round count to a start round.
package keccak_pkg;

    localparam int ROW_SIZE         = 5;
    localparam int COL_SIZE         = 5;
    localparam int LANE_SIZE        = 64;
    localparam int ROUND_INDEX_SIZE = 5;
    localparam int STEP_SEL_WIDTH   = 3;
    localparam int NUM_ROUNDS       = 24;
    localparam int STEPS_PER_ROUND  = 5;

    localparam logic [ROUND_INDEX_SIZE-1:0] LAST_ROUND = ROUND_INDEX_SIZE'(NUM_ROUNDS - 1);

    typedef enum logic [STEP_SEL_WIDTH-1:0] {
        THETA_STEP = 3'd0,
        RHO_STEP   = 3'd1,
        PI_STEP    = 3'd2,
        CHI_STEP   = 3'd3,
        IOTA_STEP  = 3'd4,
        IDLE_STEP  = 3'd7
    } keccak_step_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } keccak_seq_state_t;

    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] keccak_state_t;

    // Keccak-p[1600,nr] runs the last nr rounds; counts above 24 saturate.
    function automatic logic [ROUND_INDEX_SIZE-1:0] first_round_for(
        input logic [ROUND_INDEX_SIZE:0] nr
    );
        if (int'(nr) >= NUM_ROUNDS) begin
            return '0;
        end
        return ROUND_INDEX_SIZE'(NUM_ROUNDS - int'(nr));
    endfunction

endpackage

// File: rtl/keccak_perm_sequencer.sv
// Walks an external combinational keccak_step_unit through every step of every round.
// Optional KECCAK_REDUCED_ROUNDS_EN adds num_rounds_i for Keccak-p[1600,nr].
module keccak_perm_sequencer
    import keccak_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_valid_i,
    output logic                        start_ready_o,
    input  keccak_state_t               state_i,
`ifdef KECCAK_REDUCED_ROUNDS_EN
    input  logic [ROUND_INDEX_SIZE:0]   num_rounds_i,
`endif
    output logic                        done_valid_o,
    input  logic                        done_ready_i,
    output keccak_state_t               state_o,
    output logic                        busy_o,
    output keccak_state_t               step_state_o,
    output logic [STEP_SEL_WIDTH-1:0]   step_sel_o,
    output logic [ROUND_INDEX_SIZE-1:0] round_index_o,
    input  keccak_state_t               step_result_i
);

    keccak_seq_state_t             r_fsm;
    keccak_seq_state_t             w_fsmNext;
    keccak_state_t                 r_state;
    keccak_step_t                  r_step;
    logic [ROUND_INDEX_SIZE-1:0]   r_round;
    logic [ROUND_INDEX_SIZE-1:0]   w_firstRound;
    logic                          w_skipRun;
    logic                          w_lastStep;

`ifdef KECCAK_REDUCED_ROUNDS_EN
    assign w_firstRound = first_round_for(num_rounds_i);
    assign w_skipRun    = (num_rounds_i == '0);
`else
    assign w_firstRound = '0;
    assign w_skipRun    = 1'b0;
`endif

    assign w_lastStep    = (r_step == IOTA_STEP) && (r_round == LAST_ROUND);
    assign state_o       = r_state;
    assign step_state_o  = r_state;
    assign round_index_o = r_round;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsmNext;
        end
    end

    always_comb begin
        w_fsmNext     = r_fsm;
        start_ready_o = 1'b0;
        done_valid_o  = 1'b0;
        busy_o        = 1'b0;
        step_sel_o    = IDLE_STEP;
        case (r_fsm)
            IDLE: begin
                start_ready_o = 1'b1;
                if (start_valid_i) begin
                    w_fsmNext = w_skipRun ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o     = 1'b1;
                step_sel_o = r_step;
                if (w_lastStep) begin
                    w_fsmNext = DONE;
                end
            end
            DONE: begin
                done_valid_o = 1'b1;
                if (done_ready_i) begin
                    w_fsmNext = IDLE;
                end
            end
            default: w_fsmNext = IDLE;
        endcase
    end

    // A zero-round request leaves the round index untouched since no step is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= '0;
            r_step  <= THETA_STEP;
            r_round <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (start_valid_i) begin
                        r_state <= state_i;
                        r_step  <= THETA_STEP;
                        if (!w_skipRun) begin
                            r_round <= w_firstRound;
                        end
                    end
                end
                RUN: begin
                    r_state <= step_result_i;
                    if (r_step == IOTA_STEP) begin
                        r_step <= THETA_STEP;
                        if (r_round != LAST_ROUND) begin
                            r_round <= r_round + 1'b1;
                        end
                    end else begin
                        r_step <= keccak_step_t'(r_step + 3'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/keccak_perm_sequencer.md
# keccak_perm_sequencer

- Drives `keccak_step_unit` from the initiator side.
- Accepts a 1600-bit state over a valid/ready handshake.
- Walks the step unit through θ, ρ, π, χ, ι for every round, one step per cycle, and registers each result back into its state register.
- Returns the permuted state over a second valid/ready handshake.
- Sits between the sponge absorb/squeeze logic and the combinational step unit, so one step unit can be shared behind a single sequencer.

## Interface
Parameters:
- none; all sizes come from `keccak_pkg` (`ROW_SIZE`, `COL_SIZE`, `LANE_SIZE`, `ROUND_INDEX_SIZE`, `STEP_SEL_WIDTH`).

Ports:
- `clk` in 1: clock; every register updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start_valid_i` in 1: input state offered.
- `start_ready_o` out 1: sequencer can accept a state.
- `state_i` in 1600 (`[ROW_SIZE][COL_SIZE][LANE_SIZE]`): state to permute.
- `done_valid_o` out 1: permuted state available.
- `done_ready_i` in 1: consumer accepts the result.
- `state_o` out 1600: the state register.
- `busy_o` out 1: permutation in progress.
- `step_state_o` out 1600: operand to the step unit; this is the state register.
- `step_sel_o` out `STEP_SEL_WIDTH`: step select to the step unit.
- `round_index_o` out `ROUND_INDEX_SIZE`: round index to the step unit.
- `step_result_i` in 1600: combinational result from the step unit.
  - The full state is required for every step, including ι (lane [0][0] modified, all other lanes passed through).

## Operation
FSM states: IDLE, RUN, DONE.

- **IDLE**
  - `start_ready_o`=1.
  - On `start_valid_i`: load `state_i`, clear the step counter, set round to `first_round`, go to RUN.
- **RUN**
  - Step counter cycles THETA→RHO→PI→CHI→IOTA.
  - Each cycle the state register is loaded with `step_result_i`.
  - After IOTA, the round increments.
  - After the IOTA of round 23, go to DONE.
- **DONE**
  - `done_valid_o`=1 and `state_o` is held stable.
  - On `done_ready_i`, go to IDLE.
- `step_sel_o`
  - Carries `IDLE_STEP` whenever the state is not RUN.
  - In RUN it carries the current step code.
- `round_index_o` is held at the last value outside RUN.
- `first_round` is 0 (fixed 24 rounds) unless configured otherwise (see Configuration).
- `start_valid_i` is ignored outside IDLE.
- `done_ready_i` is ignored outside DONE.
- No abort input; only `rst_n` terminates a permutation.

## Timing
- Reset values:
  - FSM=IDLE; state register=0.
  - `start_ready_o`=1; `done_valid_o`=0; `busy_o`=0.
  - `step_sel_o`=`IDLE_STEP`; `round_index_o`=0.
- Handshake at cycle 0 (state captured on that edge) → RUN occupies cycles 1..120 (5 steps × 24 rounds) → `done_valid_o` high from cycle 121.
- Latency is 121 cycles from accept to result valid with zero backpressure.
- `done_valid_o` and `state_o` stay stable until `done_ready_i`.
  - Transfer on the cycle both are high; IDLE the next cycle.
  - Minimum start-to-start interval is 122 cycles.
- `busy_o` equals (state==RUN).
- Reset asserted mid-RUN or in DONE:
  - Next cycle is IDLE with state=0.
  - No `done_valid_o` pulse.
- Step-unit path (state register → step unit → state register) is single-cycle and unregistered at the step unit.

## Configuration
- `KECCAK_REDUCED_ROUNDS_EN` defined:
  - Adds input `num_rounds_i` (`ROUND_INDEX_SIZE`+1 bits), sampled at the start handshake.
  - Runs Keccak-p[1600,nr]: rounds `24−nr`..23.
  - `nr`=0 goes straight from IDLE to DONE with the state unchanged (result valid at cycle 1).
  - `nr`>24 is clamped to 24.
  - Latency is `5·nr+1`.
- Undefined: port absent, always 24 rounds, `first_round`=0.

## Structure
- `keccak_pkg` gains:
  - `NUM_ROUNDS`=24 and `STEPS_PER_ROUND`=5.
  - An FSM state enum `keccak_seq_state_t` {IDLE, RUN, DONE}.
- Existing step-select codes and size constants are reused.
- No sub-module: the step unit stays external so integration can share it; the FSM and counters are flat in this module.

## Test plan
- All-zero `state_i`, no backpressure → `done_valid_o` at cycle 121; lane[0][0]=0xF1258F7940E1DDE7; all 25 lanes match the Keccak-f[1600] reference model.
- Monitor the step-unit ports during one run → `step_sel_o` sequence THETA,RHO,PI,CHI,IOTA ×24; `round_index_o` 0..23, each value held for 5 cycles; `IDLE_STEP` outside RUN.
- Hold `done_ready_i`=0 for 50 cycles after done → `state_o` and `done_valid_o` stable; `start_ready_o`=0; a `start_valid_i` pulse is ignored.
- Drop `rst_n` at cycle 60 of a run → next cycle IDLE, `state_o`=0, `busy_o`=0; a fresh start then gives the correct result.
- `KECCAK_REDUCED_ROUNDS_EN`, `num_rounds_i`=12 on zero state → `round_index_o` 12..23, done at cycle 61, result matches Keccak-p[1600,12].
- `KECCAK_REDUCED_ROUNDS_EN`, `num_rounds_i`=0 with random state → `done_valid_o` at cycle 1, `state_o`==`state_i`.
